w_slicer: RTL and testbench

Parametrised weight slicer/broadcaster feeding the BitFusion PE array from the weight buffer read port. It accepts one WORD_W-bit weight word per valid/ready handshake, splits it into 1, 2 or 4 beats according to the weight bitwidth mode, and replicates each beat's elements across all output lanes. It supersedes the fixed 32-bit rd_en-driven weight mux with back-pressure, arbitrary lane count and optional zero-bubble prefetch.

---
 rtl/w_slicer_pkg.sv | 43 ++++
 rtl/w_slicer_lane_map.sv | 61 ++++++
 rtl/w_slicer.sv | 207 ++++++++++++++++++++
 tb/tb_w_slicer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_slicer_pkg.sv
// -----------------------------------------------------------------------------
// w_slicer_pkg
//
// Shared types and helpers for the weight slicer.
//
// Contents:
//   mode_t      one-hot weight bitwidth mode (2b / 4b / 8b)
//   state_t     slicer control states (IDLE, STREAM)
//   group_size  elements carried per beat for a given mode
//   mode_legal  true when a raw 3-bit mode value is one of the legal one-hot codes
//
// Build option: none here; W_SLICER_PREFETCH_EN only affects w_slicer.
// -----------------------------------------------------------------------------
package w_slicer_pkg;

    typedef enum logic [2:0] {
        MODE_2B = 3'b001,
        MODE_4B = 3'b010,
        MODE_8B = 3'b100
    } mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Narrower weights pack more elements into one PE input, so each beat
    // carries more distinct elements and fewer beats are needed per word.
    function automatic int group_size(input mode_t mode);
        case (mode)
            MODE_2B: return 4;
            MODE_4B: return 2;
            default: return 1;
        endcase
    endfunction

    // Anything that is not exactly one of the three one-hot codes is illegal,
    // including all-zero and multi-hot values.
    function automatic logic mode_legal(input logic [2:0] bw);
        return (bw == MODE_2B) || (bw == MODE_4B) || (bw == MODE_8B);
    endfunction

endpackage

// File: rtl/w_slicer_lane_map.sv
// -----------------------------------------------------------------------------
// w_slicer_lane_map
//
// Purely combinational beat builder. For the selected beat of a held weight
// word, it picks G consecutive elements and replicates each one across
// LANES/G adjacent output lanes. Output lane j of beat b carries element
// b*G + j/R, with G = group_size(mode) and R = LANES/G.
//
// Parameters:
//   WORD_W         word width in bits
//   ELEM_W         element width in bits
//
// Ports:
//   word           packed weight word, element 0 in the LSBs
//   mode           weight bitwidth mode of that word
//   beat           beat index within the word
//   data_out_next  replicated beat, to be registered by the parent
// -----------------------------------------------------------------------------
module w_slicer_lane_map
    import w_slicer_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ELEM_W = 8
) (
    input  logic [WORD_W-1:0]                    word,
    input  mode_t                                mode,
    input  logic [$clog2(WORD_W/ELEM_W)-1:0]     beat,
    output logic [WORD_W-1:0]                    data_out_next
);

    localparam int LANES = WORD_W / ELEM_W;

    // Group and replication factors are fixed per mode, so every index
    // below reduces to a shift plus a constant per lane.
    localparam int G_2B = group_size(MODE_2B);
    localparam int G_4B = group_size(MODE_4B);
    localparam int G_8B = group_size(MODE_8B);
    localparam int R_2B = LANES / G_2B;
    localparam int R_4B = LANES / G_4B;
    localparam int R_8B = LANES / G_8B;

    int elem;

    // The parent feeds beat+1 speculatively even on the terminal beat, so the
    // element index is wrapped to keep the select inside the word; the value
    // produced in that case is never registered.
    always_comb begin
        data_out_next = '0;
        elem          = 0;
        for (int j = 0; j < LANES; j++) begin
            case (mode)
                MODE_2B: elem = int'(beat) * G_2B + j / R_2B;
                MODE_4B: elem = int'(beat) * G_4B + j / R_4B;
                default: elem = int'(beat) * G_8B + j / R_8B;
            endcase
            elem = elem % LANES;
            data_out_next[j*ELEM_W +: ELEM_W] = word[elem*ELEM_W +: ELEM_W];
        end
    end

endmodule

// File: rtl/w_slicer.sv
// -----------------------------------------------------------------------------
// w_slicer
//
// Weight slicer/broadcaster between the weight buffer read port and the
// BitFusion PE array. One WORD_W-bit word is taken per in_valid/in_ready
// handshake, split into LANES/G beats (G = elements per beat for the mode)
// and each beat's elements are replicated across all LANES output lanes.
// Beats leave on a registered valid/ready interface with back-pressure.
//
// Build option:
//   W_SLICER_PREFETCH_EN  when defined, a one-entry prefetch register holds
//                         the next word so its first beat follows the last
//                         beat of the current word with no bubble. When not
//                         defined, the slicer only accepts a word while idle
//                         and leaves one empty cycle between words.
//
// Parameters:
//   WORD_W  word width (WORD_W/ELEM_W must be a power of two, at least 4)
//   ELEM_W  element width
//
// Ports:
//   clk             clock
//   nRST            synchronous active-low reset
//   input_bitwidth  one-hot mode (001=2b, 010=4b, 100=8b), sampled on accept
//   clear           synchronous flush of all held words
//   in_valid        data_in valid
//   in_ready        slicer can accept data_in
//   data_in         packed weight word, element 0 in the LSBs
//   out_valid       data_out valid
//   out_ready       PE array consumes data_out
//   data_out        replicated beat (registered)
//   out_last        data_out is the final beat of its word
//   mode_err        one-cycle pulse after an illegal mode was accepted
// -----------------------------------------------------------------------------
module w_slicer
    import w_slicer_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [2:0]        input_bitwidth,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              out_last,
    output logic              mode_err
);

    localparam int LANES  = WORD_W / ELEM_W;
    localparam int BEAT_W = $clog2(LANES);

    // Word currently being streamed out.
    state_t             state;
    logic [WORD_W-1:0]  held_word;
    mode_t              held_mode;
    logic [BEAT_W-1:0]  beat;

    // Prefetch entry; tied off when the option is not built.
    logic               pf_valid;
    logic [WORD_W-1:0]  pf_word;
    mode_t              pf_mode;

    logic               hs_in;
    logic               hs_out;
    logic               last_hs;
    logic               in_legal;
    logic               main_free;
    logic               load_pf;
    logic               load_new;

    logic [WORD_W-1:0]  map_word;
    mode_t              map_mode;
    logic [BEAT_W-1:0]  map_beat;
    logic [WORD_W-1:0]  map_data;
    logic               map_last;

    assign hs_in    = in_valid && in_ready;
    assign hs_out   = out_valid && out_ready;
    assign last_hs  = hs_out && out_last;
    assign in_legal = mode_legal(input_bitwidth);

    // The main register can take a new word this edge if it is empty or its
    // final beat is being consumed right now.
    assign main_free = (state == IDLE) || last_hs;

    // A waiting prefetched word always wins over the input port; in_ready is
    // low whenever the prefetch entry is full, so both cannot collide.
    assign load_pf  = last_hs && pf_valid;
    assign load_new = hs_in && in_legal && main_free && !pf_valid;

`ifdef W_SLICER_PREFETCH_EN
    logic store_pf;

    // A legal word arriving while the main register is still busy parks in
    // the prefetch entry until the current word's last beat is taken.
    assign store_pf = hs_in && in_legal && !main_free;
    assign in_ready = nRST && !clear && !pf_valid;
`else
    assign pf_valid = 1'b0;
    assign pf_word  = '0;
    assign pf_mode  = MODE_8B;
    assign in_ready = nRST && !clear && (state == IDLE);
`endif

    // Select what the single lane map works on: the first beat of whichever
    // word is being loaded, otherwise the following beat of the held word.
    always_comb begin
        map_word = held_word;
        map_mode = held_mode;
        map_beat = beat + 1'b1;
        if (load_pf) begin
            map_word = pf_word;
            map_mode = pf_mode;
            map_beat = '0;
        end else if (load_new) begin
            map_word = data_in;
            map_mode = mode_t'(input_bitwidth);
            map_beat = '0;
        end
    end

    // Terminal beat is B-1 with B = LANES/G; computing it here lets out_last
    // be registered alongside data_out.
    always_comb begin
        map_last = (int'(map_beat) == (LANES / group_size(map_mode)) - 1);
    end

    w_slicer_lane_map #(
        .WORD_W (WORD_W),
        .ELEM_W (ELEM_W)
    ) lane_map (
        .word          (map_word),
        .mode          (map_mode),
        .beat          (map_beat),
        .data_out_next (map_data)
    );

    // Control FSM and all registered outputs. Reset clears everything,
    // clear drops held words but leaves data_out as it was, and otherwise a
    // word load takes priority over advancing or retiring the current word
    // (a load on the last-beat edge is what gives back-to-back streaming).
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state     <= IDLE;
            held_word <= '0;
            held_mode <= MODE_8B;
            beat      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            mode_err  <= 1'b0;
`ifdef W_SLICER_PREFETCH_EN
            pf_valid  <= 1'b0;
            pf_word   <= '0;
            pf_mode   <= MODE_8B;
`endif
        end else if (clear) begin
            state     <= IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            mode_err  <= 1'b0;
`ifdef W_SLICER_PREFETCH_EN
            pf_valid  <= 1'b0;
`endif
        end else begin
            // Illegal words are consumed and dropped; only this flag shows it.
            mode_err <= hs_in && !in_legal;

            if (load_pf || load_new) begin
                state     <= STREAM;
                held_word <= map_word;
                held_mode <= map_mode;
                beat      <= '0;
                data_out  <= map_data;
                out_valid <= 1'b1;
                out_last  <= map_last;
            end else if (hs_out && !out_last) begin
                beat      <= map_beat;
                data_out  <= map_data;
                out_last  <= map_last;
            end else if (last_hs) begin
                state     <= IDLE;
                beat      <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

`ifdef W_SLICER_PREFETCH_EN
            if (store_pf) begin
                pf_valid <= 1'b1;
                pf_word  <= data_in;
                pf_mode  <= mode_t'(input_bitwidth);
            end else if (load_pf) begin
                pf_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_w_slicer.sv
// -----------------------------------------------------------------------------
// tb_w_slicer
//
// Self-checking bench for w_slicer with WORD_W=32, ELEM_W=8 (four lanes).
// Expected beats come from a small reference model that builds each beat by
// replicating bytes of the word according to the mode. Directed cases use
// literal expected words. Honours W_SLICER_PREFETCH_EN for the back-to-back
// gap expectation.
// -----------------------------------------------------------------------------
module tb_w_slicer;

    logic        clk = 1'b0;
    logic        nRST;
    logic [2:0]  input_bitwidth;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        out_last;
    logic        mode_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_data[$];
    bit          got_last[$];
    logic [31:0] exp_q[$];
    int          stall_changes;

    w_slicer #(
        .WORD_W (32),
        .ELEM_W (8)
    ) dut (
        .clk            (clk),
        .nRST           (nRST),
        .input_bitwidth (input_bitwidth),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .out_last       (out_last),
        .mode_err       (mode_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Reference model: 8b repeats each byte on all lanes, 4b puts the higher
    // byte of each pair on the upper two lanes, 2b passes the word as is.
    task automatic model_beats(input logic [31:0] word, input logic [2:0] mode);
        logic [7:0] lo;
        logic [7:0] hi;
        exp_q.delete();
        case (mode)
            3'b100: for (int b = 0; b < 4; b++) begin
                lo = 8'(word >> (8 * b));
                exp_q.push_back({4{lo}});
            end
            3'b010: for (int b = 0; b < 2; b++) begin
                lo = 8'(word >> (16 * b));
                hi = 8'(word >> (16 * b + 8));
                exp_q.push_back({hi, hi, lo, lo});
            end
            3'b001: exp_q.push_back(word);
            default: ;
        endcase
    endtask

    // Drives one word and records every consumed beat; optionally toggles
    // out_ready randomly and counts any change of held output while stalled.
    task automatic send_and_collect(input logic [31:0] word, input logic [2:0] mode,
                                    input bit stall, input int nbeats);
        bit          accepted;
        bit          take_in;
        bit          take_out;
        bit          stalled;
        logic [31:0] held;
        bit          held_last;
        int          cyc;
        got_data.delete();
        got_last.delete();
        stall_changes = 0;
        accepted  = 0;
        stalled   = 0;
        held      = '0;
        held_last = 0;
        cyc       = 0;
        @(negedge clk);
        in_valid       = 1'b1;
        data_in        = word;
        input_bitwidth = mode;
        out_ready      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        while (got_data.size() < nbeats && cyc < 200) begin
            #1;
            if (stalled && (data_out !== held || out_last !== held_last || out_valid !== 1'b1))
                stall_changes++;
            take_in   = in_valid && in_ready;
            take_out  = out_valid && out_ready;
            stalled   = out_valid && !out_ready;
            held      = data_out;
            held_last = out_last;
            if (take_out) begin
                got_data.push_back(data_out);
                got_last.push_back(out_last);
            end
            if (got_data.size() < nbeats) begin
                @(negedge clk);
                if (take_in) accepted = 1;
                if (accepted) in_valid = 1'b0;
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Starts an 8b word and returns at the point where beat 2 is on data_out.
    task automatic reach_beat2(input logic [31:0] word, output int seen);
        int cyc;
        seen = 0;
        cyc  = 0;
        @(negedge clk);
        in_valid       = 1'b1;
        data_in        = word;
        input_bitwidth = 3'b100;
        out_ready      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < 20) begin
            #1;
            if (out_valid) begin
                if (seen == 2) break;
                seen++;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        nRST           = 1'b0;
        clear          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        data_in        = '0;
        input_bitwidth = 3'b100;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last got=%0b exp=0", out_last); end
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data_out got=%h exp=0", data_out); end
        n_checks++; if (mode_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mode_err got=%0b exp=0", mode_err); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready_low got=%0b exp=0", in_ready); end
        nRST = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready_release got=%0b exp=1", in_ready); end
    endtask

    task automatic test_8b();
        logic [31:0] exp8 [4];
        exp8 = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        send_and_collect(32'hDDCCBBAA, 3'b100, 1'b0, 4);
        n_checks++;
        if (got_data.size() != 4) begin
            n_fail++; $display("[TB] FAIL b8_count got=%0d exp=4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_data[i] !== exp8[i] || got_last[i] !== (i == 3)) begin
                    n_fail++;
                    $display("[TB] FAIL b8_beat%0d got=%h/%0b exp=%h/%0b", i, got_data[i], got_last[i], exp8[i], (i == 3));
                end
            end
        end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b8_idle_after got=%0b/%0b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_4b_2b();
        send_and_collect(32'hDDCCBBAA, 3'b010, 1'b0, 2);
        n_checks++;
        if (got_data.size() != 2) begin
            n_fail++; $display("[TB] FAIL b4_count got=%0d exp=2", got_data.size());
        end else begin
            n_checks++; if (got_data[0] !== 32'hBBBBAAAA || got_last[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL b4_beat0 got=%h/%0b exp=bbbbaaaa/0", got_data[0], got_last[0]); end
            n_checks++; if (got_data[1] !== 32'hDDDDCCCC || got_last[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL b4_beat1 got=%h/%0b exp=ddddcccc/1", got_data[1], got_last[1]); end
        end
        send_and_collect(32'hDDCCBBAA, 3'b001, 1'b0, 1);
        n_checks++;
        if (got_data.size() != 1) begin
            n_fail++; $display("[TB] FAIL b2_count got=%0d exp=1", got_data.size());
        end else begin
            n_checks++; if (got_data[0] !== 32'hDDCCBBAA || got_last[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL b2_beat0 got=%h/%0b exp=ddccbbaa/1", got_data[0], got_last[0]); end
        end
    endtask

    task automatic test_random(input bit stall, input int nwords);
        logic [31:0] word;
        logic [2:0]  mode;
        for (int w = 0; w < nwords; w++) begin
            word = $urandom;
            mode = 3'b001 << $urandom_range(0, 2);
            model_beats(word, mode);
            send_and_collect(word, mode, stall, exp_q.size());
            n_checks++;
            if (got_data.size() != exp_q.size()) begin
                n_fail++; $display("[TB] FAIL rand_count word=%0d got=%0d exp=%0d", w, got_data.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                        n_fail++;
                        $display("[TB] FAIL rand_beat word=%0d beat=%0d mode=%b got=%h/%0b exp=%h/%0b",
                                 w, i, mode, got_data[i], got_last[i], exp_q[i], (i == exp_q.size() - 1));
                    end
                end
            end
            if (stall) begin
                n_checks++; if (stall_changes != 0) begin n_fail++; $display("[TB] FAIL stall_hold word=%0d got=%0d changes exp=0", w, stall_changes); end
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  bad_modes [2];
        logic [31:0] word;
        bad_modes = '{3'b011, 3'b000};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid       = 1'b1;
            data_in        = $urandom;
            input_bitwidth = bad_modes[k];
            out_ready      = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_checks++; if (mode_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_pulse mode=%b got err=%0b valid=%0b exp 1/0", bad_modes[k], mode_err, out_valid); end
            @(negedge clk);
            #1;
            n_checks++; if (mode_err !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_after mode=%b got err=%0b valid=%0b exp 0/0", bad_modes[k], mode_err, out_valid); end
        end
        word = $urandom;
        model_beats(word, 3'b010);
        send_and_collect(word, 3'b010, 1'b0, 2);
        n_checks++;
        if (got_data.size() != 2 || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]) begin
            n_fail++; $display("[TB] FAIL illegal_recover got_count=%0d exp=2 first_exp=%h", got_data.size(), exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[$];
        int          idx;
        int          gaps;
        int          cyc;
        int          exp_gaps;
        bit          take_in;
`ifdef W_SLICER_PREFETCH_EN
        exp_gaps = 0;
`else
        exp_gaps = 5;
`endif
        for (int i = 0; i < 6; i++) words.push_back($urandom);
        got_data.delete();
        idx  = 0;
        gaps = 0;
        cyc  = 0;
        @(negedge clk);
        in_valid       = 1'b1;
        data_in        = words[0];
        input_bitwidth = 3'b001;
        out_ready      = 1'b1;
        while (got_data.size() < 6 && cyc < 100) begin
            #1;
            take_in = in_valid && in_ready;
            if (out_valid) got_data.push_back(data_out);
            else if (got_data.size() > 0) gaps++;
            if (got_data.size() < 6) begin
                @(negedge clk);
                cyc++;
                if (take_in) begin
                    idx++;
                    if (idx < 6) data_in = words[idx];
                    else in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got_data.size() != 6) begin
            n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=6", got_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (got_data[i] !== words[i]) begin n_fail++; $display("[TB] FAIL b2b_data%0d got=%h exp=%h", i, got_data[i], words[i]); end
            end
        end
        n_checks++; if (gaps != exp_gaps) begin n_fail++; $display("[TB] FAIL b2b_gaps got=%0d exp=%0d", gaps, exp_gaps); end
    endtask

    task automatic test_flush();
        int seen;
        // Clear in the middle of the third beat.
        reach_beat2(32'hDDCCBBAA, seen);
        n_checks++; if (seen != 2 || data_out !== 32'hCCCCCCCC) begin n_fail++; $display("[TB] FAIL clear_reach got seen=%0d data=%h exp 2/cccccccc", seen, data_out); end
        clear = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_in_ready got=%0b exp=0", in_ready); end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_after got=%0b/%0b exp=0/1", out_valid, in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_no_partial got=%0b exp=0", out_valid); end

        // Reset in the middle of the third beat.
        reach_beat2(32'h44332211, seen);
        n_checks++; if (seen != 2 || data_out !== 32'h33333333) begin n_fail++; $display("[TB] FAIL rst_reach got seen=%0d data=%h exp 2/33333333", seen, data_out); end
        nRST = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready got=%0b exp=0", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || data_out !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid got=%0b/%h/%0b exp=0/0/0", out_valid, data_out, out_last); end
        nRST = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_partial got=%0b exp=0", out_valid); end

        // A fresh word streams normally after the flush.
        model_beats(32'h8899AABB, 3'b100);
        send_and_collect(32'h8899AABB, 3'b100, 1'b0, 4);
        n_checks++;
        if (got_data.size() != 4 || got_data[0] !== exp_q[0] || got_data[3] !== exp_q[3] || got_last[3] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_recover got_count=%0d exp=4", got_data.size());
        end
    endtask

    initial begin
        nRST           = 1'b0;
        clear          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        data_in        = '0;
        input_bitwidth = 3'b100;
        $display("[TB] starting w_slicer bench");
        test_reset();
        test_8b();
        test_4b_2b();
        test_random(1'b0, 20);
        test_random(1'b1, 8);
        test_illegal();
        test_back_to_back();
        test_flush();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
